// File: rtl/dice_pkg.sv
// Shared dice display constants: segment patterns, face type, decoder states.
// seg_to_face() maps an active-low a..g pattern to 1..6, or 0 if not a face.
package dice_pkg;

   typedef logic [2:0] face_t;

   typedef enum logic [1:0] {
      BLANK   = 2'd0,
      SETTLE  = 2'd1,
      HELD    = 2'd2,
      ILLEGAL = 2'd3
   } seg_state_e;

   // active-low, bit6=a .. bit0=g
   localparam logic [6:0] SEG_1     = 7'b1001111;
   localparam logic [6:0] SEG_2     = 7'b0010010;
   localparam logic [6:0] SEG_3     = 7'b0000110;
   localparam logic [6:0] SEG_4     = 7'b1001100;
   localparam logic [6:0] SEG_5     = 7'b0100100;
   localparam logic [6:0] SEG_6     = 7'b0100000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   function automatic face_t seg_to_face(input logic [6:0] seg);
      face_t f;
      case (seg)
         SEG_1:   f = 3'd1;
         SEG_2:   f = 3'd2;
         SEG_3:   f = 3'd3;
         SEG_4:   f = 3'd4;
         SEG_5:   f = 3'd5;
         SEG_6:   f = 3'd6;
         default: f = 3'd0;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/dice_seg_decoder_if.sv
// Bus between the dice segment decoder and its user.
// master: drives seg_in/err_clr/hist_sel/hist_clr; slave: drives face/face_valid/err_illegal/hist_data.
interface dice_seg_decoder_if #(
   parameter int COUNT_W = 16
);
   import dice_pkg::*;

   logic [6:0]         seg_in;
   face_t              face;
   logic               face_valid;
   logic               err_illegal;
   logic               err_clr;
   logic [2:0]         hist_sel;
   logic [COUNT_W-1:0] hist_data;
   logic               hist_clr;

   modport master (
      output seg_in, err_clr, hist_sel, hist_clr,
      input  face, face_valid, err_illegal, hist_data
   );

   modport slave (
      input  seg_in, err_clr, hist_sel, hist_clr,
      output face, face_valid, err_illegal, hist_data
   );

endinterface

// File: rtl/dice_hist_bank.sv
// Six saturating roll counters (faces 1..6) with global clear and registered read.
// Ports: clk, rst_n, i_clr, i_inc, i_idx (face to bump), i_sel (read index), o_data.
module dice_hist_bank
   import dice_pkg::*;
#(
   parameter int COUNT_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_clr,
   input  logic               i_inc,
   input  face_t              i_idx,
   input  face_t              i_sel,
   output logic [COUNT_W-1:0] o_data
);

   logic [COUNT_W-1:0] r_cnt [6];
   logic [COUNT_W-1:0] r_data;
   logic [COUNT_W-1:0] w_rd;

   for (genvar g = 0; g < 6; g++) begin : g_cnt
      logic w_hit;
      assign w_hit = i_inc && (i_idx == face_t'(g + 1));

      // clear beats a same-cycle increment
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_cnt[g] <= '0;
         end else if (i_clr) begin
            r_cnt[g] <= '0;
         end else if (w_hit && (r_cnt[g] != '1)) begin
            r_cnt[g] <= r_cnt[g] + 1'b1;
         end
      end
   end

   always_comb begin
      w_rd = '0;
      case (i_sel)
         3'd1:    w_rd = r_cnt[0];
         3'd2:    w_rd = r_cnt[1];
         3'd3:    w_rd = r_cnt[2];
         3'd4:    w_rd = r_cnt[3];
         3'd5:    w_rd = r_cnt[4];
         3'd6:    w_rd = r_cnt[5];
         default: w_rd = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data <= '0;
      end else begin
         r_data <= w_rd;
      end
   end

   assign o_data = r_data;

endmodule

// File: rtl/dice_seg_decoder.sv
// Decodes the dice core's active-low segment bus back to a face, reports settled rolls once,
// flags illegal patterns and keeps a roll histogram. Ports: clk, rst_n, bus (slave side).
module dice_seg_decoder
   import dice_pkg::*;
#(
   parameter int STABLE_CYCLES = 16,
   parameter int COUNT_W       = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   dice_seg_decoder_if.slave   bus
);

   localparam int              CNT_W   = $clog2(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

   localparam logic [1:0] ST_BLANK   = 2'(BLANK);
   localparam logic [1:0] ST_SETTLE  = 2'(SETTLE);
   localparam logic [1:0] ST_HELD    = 2'(HELD);
   localparam logic [1:0] ST_ILLEGAL = 2'(ILLEGAL);

   logic [6:0]       r_sync1;
   logic [6:0]       r_sync2;
   logic [6:0]       r_prev;
   logic [CNT_W-1:0] r_cnt;
   logic             r_reported;
   logic [1:0]       r_state;
   face_t            r_face;
   logic             r_fv;
   logic             r_err;

   logic [6:0]       w_s;
   logic             w_chg;
   face_t            w_face;
   logic             w_blank;
   logic             w_illegal;
   logic [1:0]       w_nstate;
   logic             w_report;
   logic             w_set_err;

   assign w_s       = r_sync2;
   assign w_chg     = (w_s != r_prev);
   assign w_face    = seg_to_face(w_s);
   assign w_blank   = (w_s == SEG_BLANK);
   assign w_illegal = (w_face == 3'd0) && !w_blank;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= SEG_BLANK;
         r_sync2 <= SEG_BLANK;
         r_prev  <= SEG_BLANK;
      end else begin
         r_sync1 <= bus.seg_in;
         r_sync2 <= r_sync1;
         r_prev  <= w_s;
      end
   end

   // any change restarts the episode; the count saturates once settled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt      <= '0;
         r_reported <= 1'b0;
      end else if (w_chg) begin
         r_cnt      <= '0;
         r_reported <= 1'b0;
      end else begin
         if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + 1'b1;
         end
         if (w_report) begin
            r_reported <= 1'b1;
         end
      end
   end

   always_comb begin
      w_nstate  = r_state;
      w_report  = 1'b0;
      w_set_err = 1'b0;
      if (w_chg) begin
         w_nstate = w_blank ? ST_BLANK : ST_SETTLE;
      end else if ((r_state == ST_SETTLE) && (r_cnt == CNT_MAX)) begin
         unique case (1'b1)
            w_blank: begin
               w_nstate = ST_BLANK;
            end
            w_illegal: begin
               w_nstate  = ST_ILLEGAL;
               w_set_err = 1'b1;
            end
            default: begin
               if (!r_reported) begin
                  w_nstate = ST_HELD;
                  w_report = 1'b1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_BLANK;
         r_face  <= 3'd0;
         r_fv    <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_nstate;
         r_fv    <= w_report;
         if (w_report) begin
            r_face <= w_face;
         end
         // a fresh detection wins over a same-cycle clear
         if (w_set_err) begin
            r_err <= 1'b1;
         end else if (bus.err_clr) begin
            r_err <= 1'b0;
         end
      end
   end

   // counter bump lands on the edge closing the face_valid cycle,
   // so a hist_clr held during that cycle swallows it
   dice_hist_bank #(
      .COUNT_W (COUNT_W)
   ) u_hist (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_clr  (bus.hist_clr),
      .i_inc  (r_fv),
      .i_idx  (r_face),
      .i_sel  (bus.hist_sel),
      .o_data (bus.hist_data)
   );

   assign bus.face        = r_face;
   assign bus.face_valid  = r_fv;
   assign bus.err_illegal = r_err;

endmodule

// File: tb/tb_dice_seg_decoder.sv
// Randomized self-check of dice_seg_decoder against a run-length reference model.
// Directed episodes first, then random segment streams with random side controls.
module tb_dice_seg_decoder;

   localparam int SC = 4;
   localparam int CW = 2;
   localparam int HMAX = (1 << CW) - 1;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   dice_seg_decoder_if #(.COUNT_W(CW)) bus ();

   dice_seg_decoder #(
      .STABLE_CYCLES (SC),
      .COUNT_W       (CW)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   int n_pulse = 0;
   logic clr_on_pulse = 1'b0;

   logic [6:0] q[$];
   logic [6:0] m_last;
   int         m_run;
   int         m_face;
   int         m_fv;
   int         m_err;
   int         m_hist[1:6];
   int         m_hd;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int ref_face(input logic [6:0] p);
      case (p)
         7'b1001111: return 1;
         7'b0010010: return 2;
         7'b0000110: return 3;
         7'b1001100: return 4;
         7'b0100100: return 5;
         7'b0100000: return 6;
         default:    return 0;
      endcase
   endfunction

   task automatic model_reset();
      q.delete();
      q.push_back(7'h7F);
      q.push_back(7'h7F);
      m_last = 7'h7F;
      m_run  = 1;
      m_face = 0;
      m_fv   = 0;
      m_err  = 0;
      m_hd   = 0;
      for (int i = 1; i <= 6; i++) m_hist[i] = 0;
   endtask

   // one rising edge: the pattern seen by the decoder is the input from two edges ago
   task automatic model_edge();
      logic [6:0] s;
      int hd;
      int f;
      int set;
      hd = (bus.hist_sel >= 1 && bus.hist_sel <= 6) ? m_hist[int'(bus.hist_sel)] : 0;
      if (bus.hist_clr) begin
         for (int i = 1; i <= 6; i++) m_hist[i] = 0;
      end else if (m_fv != 0 && m_hist[m_face] < HMAX) begin
         m_hist[m_face]++;
      end
      s = q.pop_front();
      q.push_back(bus.seg_in);
      if (s == m_last) begin
         if (m_run < 1000) m_run++;
      end else begin
         m_run = 1;
      end
      m_last = s;
      m_fv = 0;
      set = 0;
      if (m_run == SC + 1) begin
         f = ref_face(s);
         if (f != 0) begin
            m_fv = 1;
            m_face = f;
         end else if (s != 7'h7F) begin
            set = 1;
         end
      end
      if (set != 0) m_err = 1;
      else if (bus.err_clr) m_err = 0;
      m_hd = hd;
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".face"}, 32'(bus.face), m_face);
      chk({tag, ".face_valid"}, 32'(bus.face_valid), m_fv);
      chk({tag, ".err_illegal"}, 32'(bus.err_illegal), m_err);
      chk({tag, ".hist_data"}, 32'(bus.hist_data), m_hd);
   endtask

   task automatic tick(input string tag);
      if (clr_on_pulse) bus.hist_clr = (m_fv != 0);
      @(posedge clk);
      model_edge();
      #1;
      if (bus.face_valid === 1'b1) n_pulse++;
      check_all(tag);
   endtask

   task automatic hold(input logic [6:0] p, input int n, input string tag);
      bus.seg_in = p;
      repeat (n) tick(tag);
   endtask

   task automatic read_hist(input int sel, input string tag);
      bus.hist_sel = 3'(sel);
      tick(tag);
      tick(tag);
   endtask

   task automatic do_reset(input string tag);
      rst_n = 1'b0;
      #1;
      model_reset();
      chk({tag, ".face"}, 32'(bus.face), 0);
      chk({tag, ".face_valid"}, 32'(bus.face_valid), 0);
      chk({tag, ".err_illegal"}, 32'(bus.err_illegal), 0);
      chk({tag, ".hist_data"}, 32'(bus.hist_data), 0);
      @(posedge clk);
      #1;
      check_all({tag, "_hold"});
      rst_n = 1'b1;
   endtask

   initial begin
      logic [6:0] p;
      int len;
      int r;

      bus.seg_in   = 7'h7F;
      bus.err_clr  = 1'b0;
      bus.hist_sel = 3'd0;
      bus.hist_clr = 1'b0;
      model_reset();
      #12;
      check_all("reset");
      rst_n = 1'b1;

      // 1: blank only
      n_pulse = 0;
      hold(7'h7F, 20, "t1");
      chk("t1.pulses", n_pulse, 0);
      for (int i = 1; i <= 6; i++) begin
         read_hist(i, "t1.rd");
         chk("t1.hist", 32'(bus.hist_data), 0);
      end

      // 2: face 3
      n_pulse = 0;
      hold(7'b0000110, 10, "t2");
      chk("t2.pulses", n_pulse, 1);
      chk("t2.face", 32'(bus.face), 3);
      read_hist(3, "t2.rd");
      chk("t2.hist3", 32'(bus.hist_data), 1);

      // 3: short 6 glitch then 5
      n_pulse = 0;
      hold(7'b0100000, 3, "t3a");
      hold(7'b0100100, 10, "t3b");
      chk("t3.pulses", n_pulse, 1);
      chk("t3.face", 32'(bus.face), 5);

      // 4: blank is legal, illegal sets sticky error
      hold(7'h7F, 8, "t4a");
      chk("t4.err_blank", 32'(bus.err_illegal), 0);
      n_pulse = 0;
      hold(7'b0110110, 8, "t4b");
      chk("t4.err_set", 32'(bus.err_illegal), 1);
      chk("t4.pulses", n_pulse, 0);
      bus.err_clr = 1'b1;
      tick("t4c");
      bus.err_clr = 1'b0;
      chk("t4.err_clr", 32'(bus.err_illegal), 0);

      // 5: repeated face, then clear on the pulse cycle
      hold(7'h7F, 6, "t5a");
      n_pulse = 0;
      hold(7'b0010010, 10, "t5b");
      hold(7'h7F, 6, "t5c");
      hold(7'b0010010, 10, "t5d");
      chk("t5.pulses", n_pulse, 2);
      read_hist(2, "t5.rd");
      chk("t5.hist2", 32'(bus.hist_data), 2);
      hold(7'h7F, 6, "t5e");
      clr_on_pulse = 1'b1;
      hold(7'b0010010, 10, "t5f");
      clr_on_pulse = 1'b0;
      bus.hist_clr = 1'b0;
      read_hist(2, "t5.rd2");
      chk("t5.hist2_clr", 32'(bus.hist_data), 0);
      chk("t5.face", 32'(bus.face), 2);
      chk("t5.pulses3", n_pulse, 3);

      // 6: saturation, then reset mid-settle
      hold(7'h7F, 6, "t6a");
      repeat (5) begin
         hold(7'b1001111, 8, "t6b");
         hold(7'h7F, 4, "t6c");
      end
      read_hist(1, "t6.rd");
      chk("t6.hist1_sat", 32'(bus.hist_data), 3);
      hold(7'b1001100, 5, "t6d");
      do_reset("t6.rst");
      n_pulse = 0;
      hold(7'b1001100, 6, "t6e");
      chk("t6.no_early", n_pulse, 0);
      tick("t6f");
      chk("t6.first", n_pulse, 1);
      chk("t6.face", 32'(bus.face), 4);

      // random streams
      for (int it = 0; it < 400; it++) begin
         r = $urandom_range(0, 9);
         case (r)
            0: p = 7'b1001111;
            1: p = 7'b0010010;
            2: p = 7'b0000110;
            3: p = 7'b1001100;
            4: p = 7'b0100100;
            5: p = 7'b0100000;
            6, 7: p = 7'h7F;
            8: begin
               p = 7'(($urandom_range(0, 127)));
               while (ref_face(p) != 0 || p == 7'h7F) p = 7'($urandom_range(0, 127));
            end
            default: p = 7'($urandom_range(0, 127));
         endcase
         len = $urandom_range(1, 10);
         bus.seg_in = p;
         for (int k = 0; k < len; k++) begin
            bus.hist_sel = 3'($urandom_range(0, 7));
            bus.err_clr  = ($urandom_range(0, 7) == 0);
            bus.hist_clr = ($urandom_range(0, 19) == 0);
            tick("rnd");
         end
         if ($urandom_range(0, 49) == 0) do_reset("rnd.rst");
      end
      bus.err_clr  = 1'b0;
      bus.hist_clr = 1'b0;
      hold(7'h7F, 10, "end");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
